// File: rtl/vga_text_pkg.sv
// -----------------------------------------------------------------------------
// vga_text_pkg
//   Constants and types shared by the VGA text path: the character screen
//   buffer, the tile-fetch front end and the glyph bitmap RAM.
//
//   COLS x ROWS   character grid (80 x 30)
//   GLYPH_W/H     glyph cell size in pixels (8 x 16)
//   BUF_DEPTH     screen-buffer entries (COLS*ROWS = 2400)
//   ADDR_W        screen-buffer address width (12 bits covers 0..4095)
//   CHAR_W        stored character code width (7-bit ASCII)
//   GX_W/GY_W     widths of the glyph column/row selectors
// -----------------------------------------------------------------------------
package vga_text_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int GLYPH_W   = 8;
  localparam int GLYPH_H   = 16;
  localparam int BUF_DEPTH = COLS * ROWS;
  localparam int ADDR_W    = 12;
  localparam int CHAR_W    = 7;
  localparam int GX_W      = $clog2(GLYPH_W);
  localparam int GY_W      = $clog2(GLYPH_H);

  typedef logic [ADDR_W-1:0] buf_addr_t;
  typedef logic [CHAR_W-1:0] char_code_t;

  // Per-pixel side-band that travels down the delay line next to the glyph
  // lookup. Syncs are active-low, so their idle value is 1.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic cursor_hit;
  } video_ctl_t;

  localparam video_ctl_t CTL_IDLE = '{
    active:     1'b0,
    hsync:      1'b1,
    vsync:      1'b1,
    cursor_hit: 1'b0
  };

endpackage

// File: rtl/text_buffer_ram.sv
// -----------------------------------------------------------------------------
// text_buffer_ram
//   Character screen buffer: simple dual-port RAM, one write port and one
//   registered read port, read-before-write on an address collision. Written
//   as a plain array with a registered read so it maps onto block RAM; the
//   contents are never reset.
//
//   Ports:
//     CLK      clock for both ports
//     wr_en    write enable (caller has already range-checked wr_addr)
//     wr_addr  write address
//     wr_data  character code to store
//     rd_en    read enable; rd_data holds its value when low
//     rd_addr  read address
//     rd_data  registered read data, valid the cycle after rd_addr
// -----------------------------------------------------------------------------
module text_buffer_ram
  import vga_text_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CHAR_W-1:0] rd_data
);

  logic [CHAR_W-1:0] mem [DEPTH];

  // Both ports in one process: the read samples the array before the
  // non-blocking write lands, which yields the old data on a collision.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/text_tile_fetch.sv
// -----------------------------------------------------------------------------
// text_tile_fetch
//   Text-mode front end of the VGA character path. Converts the timing
//   generator's pixel position into a (character, glyph_x, glyph_y) lookup for
//   the glyph bitmap RAM, overlays a blinking block cursor on the returned
//   pixel and re-aligns active/hsync/vsync with it.
//
//   Pipeline (input sampled at edge T):
//     T    screen-buffer read registered; glyph_x/glyph_y and side-band
//          (active, syncs, cursor hit) captured into stage 1
//     T+1  bitmap RAM samples character/glyph_x/glyph_y; side-band -> stage 2
//     T+2  pixel_out/active_out/hsync_out/vsync_out registered
//   Input to pixel_out is 3 clocks; every side-band signal passes 3 flops.
//
//   Ports:
//     CLK, RST_N          pixel clock, async active-low reset
//     h_count, v_count    pixel column / line from the timing generator
//     active_in           visible-area flag
//     hsync_in, vsync_in  active-low syncs
//     text_write_*        screen-buffer write port (addr = row*COLS+col)
//     cursor_enable/col/row  block cursor control
//     character, glyph_x, glyph_y  lookup presented to the bitmap RAM
//     pixel_in            bitmap RAM result, one clock after the lookup
//     pixel_out           final video bit
//     active_out, hsync_out, vsync_out  side-band aligned with pixel_out
// -----------------------------------------------------------------------------
module text_tile_fetch
  import vga_text_pkg::*;
#(
  parameter int COLS       = vga_text_pkg::COLS,
  parameter int ROWS       = vga_text_pkg::ROWS,
  parameter int CURSOR_TOP = 14,
  parameter int BLINK_BIT  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              active_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [ADDR_W-1:0] text_write_addr,
  input  logic [CHAR_W-1:0] text_write_data,
  input  logic              text_write_strobe,
  input  logic              cursor_enable,
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  output logic [CHAR_W-1:0] character,
  output logic [GX_W-1:0]   glyph_x,
  output logic [GY_W-1:0]   glyph_y,
  input  logic              pixel_in,
  output logic              pixel_out,
  output logic              active_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int DEPTH = COLS * ROWS;
  localparam int FC_W  = BLINK_BIT + 1;

  // ---------------------------------------------------------------------------
  // Address math
  // ---------------------------------------------------------------------------
  logic [6:0]        col;
  logic [4:0]        row;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              wr_en;

  assign col = h_count[9:3];
  assign row = v_count[8:4];

  // Constant multiply; for COLS = 80 this reduces to row*64 + row*16.
  // Blanking positions can land past the buffer; the result is masked by
  // active further down, so no range check is made on the read side.
  assign rd_addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

  // Lines 512 and up are always in vertical blanking, so the read can idle.
  assign rd_en = ~v_count[9];

  // Writes outside the character grid are dropped.
  assign wr_en = text_write_strobe & (text_write_addr < ADDR_W'(DEPTH));

  text_buffer_ram #(
    .DEPTH (DEPTH)
  ) u_text_buffer_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (text_write_addr),
    .wr_data (text_write_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (character)
  );

  // ---------------------------------------------------------------------------
  // Cursor hit for the current input pixel: bottom glyph rows of one cell.
  // ---------------------------------------------------------------------------
  logic       cursor_hit;
  video_ctl_t ctl_in;

  assign cursor_hit = cursor_enable
                    & (col == cursor_col)
                    & (row == cursor_row)
                    & (v_count[GY_W-1:0] >= GY_W'(CURSOR_TOP));

  assign ctl_in = '{
    active:     active_in,
    hsync:      hsync_in,
    vsync:      vsync_in,
    cursor_hit: cursor_hit
  };

  // ---------------------------------------------------------------------------
  // Pipeline registers, frame counter and output stage
  // ---------------------------------------------------------------------------
  logic [GX_W-1:0] gx_q;
  logic [GY_W-1:0] gy_q;
  video_ctl_t      ctl_d1;
  video_ctl_t      ctl_d2;
  logic [FC_W-1:0] frame_cnt;
  logic            blink_on;
  logic            vsync_fall;

  assign blink_on = frame_cnt[BLINK_BIT];

  // ctl_d1.vsync is the previous vsync_in sample, so it doubles as the
  // edge-detect register for the frame counter.
  assign vsync_fall = ctl_d1.vsync & ~vsync_in;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gx_q       <= '0;
      gy_q       <= '0;
      ctl_d1     <= CTL_IDLE;
      ctl_d2     <= CTL_IDLE;
      frame_cnt  <= '0;
      pixel_out  <= 1'b0;
      active_out <= 1'b0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
    end else begin
      // Stage 1: captured on the same edge as the buffer read, so glyph_x/y
      // leave together with the character code.
      gx_q   <= h_count[GX_W-1:0];
      gy_q   <= v_count[GY_W-1:0];
      ctl_d1 <= ctl_in;

      // Stage 2: waits out the bitmap RAM's read clock.
      ctl_d2 <= ctl_d1;

      // Stage 3: pixel_in now belongs to the stage-2 pixel.
      pixel_out  <= ctl_d2.active & (pixel_in ^ (ctl_d2.cursor_hit & blink_on));
      active_out <= ctl_d2.active;
      hsync_out  <= ctl_d2.hsync;
      vsync_out  <= ctl_d2.vsync;

      if (vsync_fall) begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  assign glyph_x = gx_q;
  assign glyph_y = gy_q;

endmodule

// File: doc/text_tile_fetch.md
Name: text_tile_fetch

Overview:
- Text-mode front end for the VGA character path.
- Sits between the VGA timing generator (upstream) and the glyph bitmap RAM (downstream, fixed 1-clock read latency).
- Holds the 80x30 character screen buffer and converts pixel coordinates into (character, glyph x, glyph y) lookups.
- Applies a blinking block cursor, re-aligns sync/active with the returned pixel, and drives the final 1-bit video.

Parameters:
COLS, 80, characters per row
ROWS, 30, character rows
CURSOR_TOP, 14, first glyph row (0-15) covered by the cursor block
BLINK_BIT, 4, frame-counter bit that gates cursor visibility (toggles every 2^BLINK_BIT frames)

Ports:
CLK  in  1  pixel clock; only clock
RST_N  in  1  asynchronous, active-low reset
h_count  in  10  pixel column from timing generator
v_count  in  10  pixel line from timing generator
active_in  in  1  visible-area flag
hsync_in  in  1  horizontal sync, active-low
vsync_in  in  1  vertical sync, active-low
text_write_addr  in  12  screen-buffer write address, row*COLS+col
text_write_data  in  7  ASCII code to store
text_write_strobe  in  1  write enable, one write per cycle
cursor_enable  in  1  cursor shown when 1
cursor_col  in  7  cursor column
cursor_row  in  5  cursor row
character  out  7  to bitmap RAM: glyph index
glyph_x  out  3  to bitmap RAM: bit within glyph row
glyph_y  out  4  to bitmap RAM: glyph row
pixel_in  in  1  from bitmap RAM, valid 1 clock after character/glyph_x/glyph_y
pixel_out  out  1  final video bit
active_out  out  1  active_in delayed to align with pixel_out
hsync_out  out  1  hsync_in delayed to align
vsync_out  out  1  vsync_in delayed to align

Behaviour:
- Reset (RST_N low, asynchronous):
  - pixel_out = 0, active_out = 0, hsync_out = 1, vsync_out = 1.
  - Pipeline registers cleared; glyph_x/glyph_y = 0; frame counter = 0.
  - Screen-buffer contents are not reset.
  - Reset mid-frame discards all in-flight pixels. Output is valid from the 3rd input sample after release.
- Address math:
  - col = h_count[9:3], row = v_count[8:4].
  - Read address = row*COLS + col, 12 bits, computed as row*64 + row*16 for the default.
  - Out-of-range addresses during blanking are don't-care; the result is masked by active.
- Pipeline. With the input sampled at edge T:
  - Stage 1 (edge T): synchronous screen-buffer read registered. glyph_x <= h_count[2:0], glyph_y <= v_count[3:0]. active/sync/cursor-hit captured.
  - Between T and T+1: character = buffer read data. glyph_x/glyph_y come from stage-1 registers, so all three are presented together.
  - Edge T+1: bitmap RAM samples. pixel_in is valid after T+1.
  - Edge T+2: pixel_out <= active_d2 & (pixel_in ^ (cursor_hit_d2 & blink_on)).
  - Total latency is 3 clocks, input sample to pixel_out. active/hsync/vsync pass through exactly 3 flops each.
- Cursor:
  - cursor_hit = cursor_enable & (col == cursor_col) & (row == cursor_row) & (v_count[3:0] >= CURSOR_TOP).
  - Cursor values are sampled at stage 1, so changes take effect on the next pixel.
- Blink:
  - vsync_in is edge-detected with one register. The frame counter (BLINK_BIT+1 bits, wraps) increments on each 1->0 transition.
  - blink_on = counter[BLINK_BIT]. Default period is 32 frames, visible on the upper 16.
- Screen-buffer write:
  - Writes on a CLK edge when text_write_strobe = 1 and text_write_addr < COLS*ROWS. Addresses >= COLS*ROWS (2400) are ignored.
  - Simultaneous read and write of the same address returns the old data (read-before-write). The new data is visible from the next read.
- active_in low forces pixel_out = 0 regardless of cursor or pixel_in.

Decomposition:
- Shared package (vga_text_pkg): COLS, ROWS, GLYPH_W = 8, GLYPH_H = 16, BUF_DEPTH = COLS*ROWS, address width 12, char width 7.
- The bitmap RAM also uses GLYPH_H and the char width from this package.
- One sub-module: text_buffer_ram. Simple dual-port, 1 write port and 1 registered read port, depth BUF_DEPTH x 7, read-before-write. It maps to block RAM.
- Address math, cursor logic, blink counter, and delay lines stay in the top module.

Test Plan:
- Reset alignment: hold RST_N low mid-line, release, drive active_in = 1 constantly -> pixel_out/active_out stay 0 for 3 clocks, then follow. hsync_out = vsync_out = 1 during reset.
- Address and latency: write 0x41 to address 81 (row 1, col 1); drive h = 8..15, v = 16 -> character = 0x41 one clock after each sample; glyph_x steps 0..7, glyph_y = 0. A bitmap model returning pattern 10110010 appears on pixel_out 3 clocks after each h sample.
- Bound and collision: write to address 2400 -> no buffer location changes. Read and write address 5 in the same cycle -> old code returned; new code returned on the next read.
- Blanking mask: active_in = 0 with pixel_in forced 1 and cursor hit -> pixel_out = 0. Sync pulses emerge delayed exactly 3 clocks, unchanged in width.
- Cursor blink: cursor_enable = 1 at (col 2, row 0), blink counter driven by 16 vsync falling edges -> glyph rows 14-15 of that cell invert pixel_in; rows 0-13 and other cells are unchanged. After 16 more edges the cell shows no inversion.
- Cursor disable: the same cursor setup with cursor_enable = 0 -> no inversion in any frame.
